button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event.sv | 155 +++++++++++++++
 tb/tb_button_event.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//
// Classifies presses of a debounced, clk-synchronous button into single short
// clicks, long presses and double clicks. Each class is reported as a
// registered one-cycle pulse. A wrapping 8-bit counter tallies every emitted
// pulse.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   LONG_MS    hold time in ms that classifies a press as long
//   DCLICK_MS  maximum release gap in ms between the two presses of a double
//              click
//   The derived cycle counts (CLK_FREQ/1000)*LONG_MS and
//   (CLK_FREQ/1000)*DCLICK_MS must both be at least 2.
//
// Ports
//   clk           in   1  system clock, rising edge
//   reset_n       in   1  asynchronous reset, active low
//   btn           in   1  debounced button level, active high
//   pressed       out  1  registered copy of btn
//   short_pulse   out  1  one-cycle pulse for a single short click
//   long_pulse    out  1  one-cycle pulse for a long press
//   double_pulse  out  1  one-cycle pulse for a double click
//   event_count   out  8  number of pulses emitted, wraps at 256
// -----------------------------------------------------------------------------
module button_event #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn,
    output logic       pressed,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       double_pulse,
    output logic [7:0] event_count
);

    localparam logic [31:0] LONG_CYC  = 32'((CLK_FREQ / 1000) * LONG_MS);
    localparam logic [31:0] GAP_CYC   = 32'((CLK_FREQ / 1000) * DCLICK_MS);
    // Timeouts fire when the counter reaches the last cycle of the window,
    // so the transition lands exactly LONG_CYC / GAP_CYC cycles after entry.
    localparam logic [31:0] LONG_LAST = LONG_CYC - 32'd1;
    localparam logic [31:0] GAP_LAST  = GAP_CYC - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        HELD_LONG
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic        btn_d;
    logic        rise;
    logic        fall;
    logic        short_next;
    logic        long_next;
    logic        double_next;
    logic        any_next;

    assign rise     = btn & ~btn_d;
    assign fall     = ~btn & btn_d;
    assign pressed  = btn_d;
    assign any_next = short_next | long_next | double_next;

    // Next-state and pulse decode. Each transition raises at most one pulse,
    // so the pulse outputs are mutually exclusive by construction.
    always_comb begin
        state_next  = state;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = PRESS1;
                end
            end
            PRESS1: begin
                // A release on the very last cycle still counts as short.
                if (fall) begin
                    state_next = WAIT_GAP;
                end else if (cnt == LONG_LAST) begin
                    state_next = HELD_LONG;
                    long_next  = 1'b1;
                end
            end
            WAIT_GAP: begin
                // A second press on the very last gap cycle still counts
                // as the start of a double click.
                if (rise) begin
                    state_next = PRESS2;
                end else if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end
            end
            PRESS2: begin
                // No long-press timeout here: the second press may be held
                // indefinitely and is still reported as a double click.
                if (fall) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end
            end
            HELD_LONG: begin
                if (fall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, edge-detect register, dwell counter and registered pulses.
    // btn_d clears in reset so a button already held at release is seen as
    // a fresh rise on the first clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            btn_d        <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            event_count  <= 8'd0;
        end else begin
            btn_d        <= btn;
            state        <= state_next;
            short_pulse  <= short_next;
            long_pulse   <= long_next;
            double_pulse <= double_next;
            if (state_next != state) begin
                cnt <= 32'd0;
            end else begin
                cnt <= cnt + 32'd1;
            end
            // Counted on the same edge the pulse register goes high, so the
            // new total is visible during the pulse cycle.
            if (any_next) begin
                event_count <= event_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//
// Directed bench for button_event with CLK_FREQ=1000, LONG_MS=10, DCLICK_MS=5
// (LONG_CYC=10, GAP_CYC=5). Expected pulses are queued with the clock index at
// which they must appear; every cycle the outputs are checked on the falling
// edge against the queue head, a running pulse total and the expected pressed
// level.
// -----------------------------------------------------------------------------
module tb_button_event;

    localparam int KIND_NONE   = 0;
    localparam int KIND_SHORT  = 1;
    localparam int KIND_LONG   = 2;
    localparam int KIND_DOUBLE = 3;
    localparam int KIND_MULTI  = 4;

    localparam int LONG_CYC = 10;
    localparam int GAP_CYC  = 5;

    logic       clk;
    logic       reset_n;
    logic       btn;
    logic       pressed;
    logic       short_pulse;
    logic       long_pulse;
    logic       double_pulse;
    logic [7:0] event_count;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         checks;
    int         failures;
    logic [7:0] exp_count;

    button_event #(
        .CLK_FREQ (1000),
        .LONG_MS  (10),
        .DCLICK_MS(5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn         (btn),
        .pressed     (pressed),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .double_pulse(double_pulse),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int observed_kind();
        int n;
        n = int'(short_pulse) + int'(long_pulse) + int'(double_pulse);
        if (n > 1) return KIND_MULTI;
        if (short_pulse === 1'b1) return KIND_SHORT;
        if (long_pulse === 1'b1) return KIND_LONG;
        if (double_pulse === 1'b1) return KIND_DOUBLE;
        if (n == 0 && (short_pulse !== 1'b0 || long_pulse !== 1'b0 || double_pulse !== 1'b0))
            return -1;
        return KIND_NONE;
    endfunction

    task automatic expect_pulse(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    // One clock: wait for the falling edge, then score all outputs.
    task automatic tick();
        int   ek;
        logic exp_pressed;
        @(negedge clk);
        ek = KIND_NONE;
        if (sb.size() > 0 && sb[0].at == cyc) begin
            ek = sb[0].kind;
            void'(sb.pop_front());
            exp_count = exp_count + 8'd1;
        end
        check("pulse_kind", observed_kind(), ek);
        if (sb.size() > 0 && sb[0].at < cyc) begin
            check("pulse_missed_at", sb[0].at, cyc);
            void'(sb.pop_front());
        end
        check("event_count", event_count, exp_count);
        exp_pressed = (reset_n === 1'b1) ? btn : 1'b0;
        check("pressed", pressed, exp_pressed);
    endtask

    task automatic hold(input logic level, input int n);
        btn = level;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        reset_n   = 1'b0;
        exp_count = 8'd0;
        sb.delete();
        #1;
        check("reset_event_count", event_count, 8'd0);
        check("reset_pressed", pressed, 1'b0);
        check("reset_pulses", {short_pulse, long_pulse, double_pulse}, 3'b000);
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int f;
        int r;
        checks    = 0;
        failures  = 0;
        exp_count = 8'd0;
        btn       = 1'b0;
        reset_n   = 1'b0;

        // Power-on reset, then idle with button released.
        do_reset(2);
        hold(1'b0, 3);

        // Short click: high 3, low; short 5 cycles after the fall.
        hold(1'b1, 3);
        f = cyc + 1;
        expect_pulse(KIND_SHORT, f + GAP_CYC);
        hold(1'b0, 8);
        check("short_count", event_count, 8'd1);

        // Long press: high 15; long 10 cycles after the rise, none on release.
        r = cyc + 1;
        expect_pulse(KIND_LONG, r + LONG_CYC);
        hold(1'b1, 15);
        hold(1'b0, 8);
        check("long_count", event_count, 8'd2);

        // Double click: high 3, low 2, high 4, low.
        hold(1'b1, 3);
        hold(1'b0, 2);
        hold(1'b1, 4);
        f = cyc + 1;
        expect_pulse(KIND_DOUBLE, f);
        hold(1'b0, 8);
        check("double_count", event_count, 8'd3);

        // Second press lands on the gap timeout cycle: rise wins, double click.
        hold(1'b1, 3);
        hold(1'b0, GAP_CYC);
        hold(1'b1, 3);
        f = cyc + 1;
        expect_pulse(KIND_DOUBLE, f);
        hold(1'b0, 8);

        // Full gap elapses, press arrives during the short pulse: short fires,
        // and the new press is an independent short click.
        hold(1'b1, 3);
        f = cyc + 1;
        expect_pulse(KIND_SHORT, f + GAP_CYC);
        hold(1'b0, GAP_CYC + 1);
        hold(1'b1, 3);
        f = cyc + 1;
        expect_pulse(KIND_SHORT, f + GAP_CYC);
        hold(1'b0, 8);
        check("gap_boundary_count", event_count, 8'd6);

        // Release on the long timeout cycle: fall wins, becomes a short click.
        hold(1'b1, LONG_CYC);
        f = cyc + 1;
        expect_pulse(KIND_SHORT, f + GAP_CYC);
        hold(1'b0, 8);
        check("long_boundary_count", event_count, 8'd7);

        // Reset in the middle of a press with the button held; the press that
        // continues after release is seen as a fresh rise.
        hold(1'b1, 6);
        do_reset(2);
        hold(1'b1, 3);
        f = cyc + 1;
        expect_pulse(KIND_SHORT, f + GAP_CYC);
        hold(1'b0, 8);
        check("post_reset_count", event_count, 8'd1);

        // Counter wrap: 256 short clicks return to 0, the 257th gives 1.
        do_reset(2);
        hold(1'b0, 2);
        for (int i = 0; i < 257; i++) begin
            hold(1'b1, 1);
            f = cyc + 1;
            expect_pulse(KIND_SHORT, f + GAP_CYC);
            hold(1'b0, GAP_CYC + 1);
            if (i == 255) check("wrap_256", event_count, 8'd0);
        end
        check("wrap_257", event_count, 8'd1);

        hold(1'b0, 4);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
